// File: rtl/spi_slv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slv_pkg
//  Purpose  : Shared types and constants for the SPI RAM slave.
//             Provides the FSM state enum, the opcode constants and a small
//             helper that sizes the receive shift register.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_slv_pkg;

  localparam int OPC_W = 2;
  localparam logic [OPC_W-1:0] OPC_WRITE = 2'b00;
  localparam logic [OPC_W-1:0] OPC_READ  = 2'b01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR    = 3'd2,
    WDATA   = 3'd3,
    RD_WAIT = 3'd4,
    RSTART  = 3'd5,
    RDATA   = 3'd6,
    IGNORE  = 3'd7
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_shift_reg
//  Purpose  : Parametrised MSB-first shift register with parallel load.
//             Load has priority over shift; serial input enters at the LSB,
//             serial output is the MSB.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             load_i/load_val_i - parallel load strobe and value
//             shift_i/sin_i     - shift strobe and serial input bit
//             q_o               - current register contents
//             sout_o            - serial output (MSB)
//  Revision : 1.0 - initial release
// ============================================================================
module spi_shift_reg
  import spi_slv_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic         sin_i,
  output logic [W-1:0] q_o,
  output logic         sout_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_val_i;
    end else if (shift_i) begin
      data_q <= {data_q[W-2:0], sin_i};
    end
  end

  assign q_o    = data_q;
  assign sout_o = data_q[W-1];

endmodule
`default_nettype wire

// File: rtl/spi_ram_slave_burst.sv
`default_nettype none
// ============================================================================
//  Module   : spi_ram_slave_burst
//  Purpose  : SPI slave bridging a 1-bit serial frame (ss_n/mosi/miso, all
//             sampled on clk) to a simple RAM port. Frame = 2-bit opcode,
//             ADDR_W-bit address, then DATA_W-bit words, all MSB first.
//             Read data is returned after a single '1' start bit.
//  Config   : SPI_SLV_BURST_EN - when defined, consecutive words follow while
//             ss_n stays low, address incrementing (wrapping) per word.
//             When undefined, one word per frame; the rest is ignored.
//  Ports    : clk, rst       - clock, synchronous active-high reset
//             ss_n_i         - frame select, active low
//             mosi_i/miso_o  - serial in / out (miso 0 when idle)
//             wr_en_o, wr_addr_o, wr_data_o - one-cycle RAM write
//             rd_req_o, rd_addr_o           - one-cycle RAM read request
//             rd_valid_i, rd_data_i         - RAM read response
//             busy_o         - high whenever the FSM is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module spi_ram_slave_burst
  import spi_slv_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              rd_req_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic              rd_valid_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              busy_o
);

  localparam int RX_W  = max_int(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(RX_W) + 1;

`ifdef SPI_SLV_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam logic [CNT_W-1:0]  C_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  C_OPC_LST = CNT_W'(OPC_W - 1);
  localparam logic [CNT_W-1:0]  C_ADR_LST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  C_DAT_LST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] C_ADR_ONE = ADDR_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [OPC_W-1:0]   opc_q, opc_d;
  logic               miso_q, miso_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;

  logic               w_rx_shift, w_tx_load, w_tx_shift;
  logic [RX_W-1:0]    w_rx_q;
  logic               w_rx_sout;
  logic [DATA_W-1:0]  w_tx_q;
  logic               w_tx_sout;
  logic [RX_W-1:0]    w_rx_next;
  logic               w_unused;

  spi_shift_reg #(.W(RX_W)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .load_i     (1'b0),
    .load_val_i ({RX_W{1'b0}}),
    .shift_i    (w_rx_shift),
    .sin_i      (mosi_i),
    .q_o        (w_rx_q),
    .sout_o     (w_rx_sout)
  );

  spi_shift_reg #(.W(DATA_W)) u_tx (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_tx_load),
    .load_val_i (rd_data_i),
    .shift_i    (w_tx_shift),
    .sin_i      (1'b0),
    .q_o        (w_tx_q),
    .sout_o     (w_tx_sout)
  );

  // Value the rx register takes at this edge; lets a field be used in the
  // same cycle its last bit is sampled.
  assign w_rx_next = {w_rx_q[RX_W-2:0], mosi_i};
  assign w_unused  = ^{w_rx_q[RX_W-1], w_rx_sout, w_tx_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    opc_d      = opc_q;
    miso_d     = 1'b0;
    wr_en_d    = 1'b0;
    rd_req_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    w_rx_shift = 1'b0;
    w_tx_load  = 1'b0;
    w_tx_shift = 1'b0;

    // Deselect aborts everything, including a read response in this cycle.
    if (state_q != IDLE && ss_n_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!ss_n_i) begin
            state_d = CMD;
            cnt_d   = '0;
          end
        end
        CMD: begin
          w_rx_shift = 1'b1;
          cnt_d      = cnt_q + C_CNT_ONE;
          if (cnt_q == C_OPC_LST) begin
            opc_d = w_rx_next[OPC_W-1:0];
            cnt_d = '0;
            if (w_rx_next[OPC_W-1:0] == OPC_WRITE || w_rx_next[OPC_W-1:0] == OPC_READ) begin
              state_d = ADDR;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR: begin
          w_rx_shift = 1'b1;
          cnt_d      = cnt_q + C_CNT_ONE;
          if (cnt_q == C_ADR_LST) begin
            addr_d = w_rx_next[ADDR_W-1:0];
            cnt_d  = '0;
            if (opc_q == OPC_READ) begin
              rd_req_d  = 1'b1;
              rd_addr_d = w_rx_next[ADDR_W-1:0];
              state_d   = RD_WAIT;
            end else begin
              state_d = WDATA;
            end
          end
        end
        WDATA: begin
          w_rx_shift = 1'b1;
          cnt_d      = cnt_q + C_CNT_ONE;
          if (cnt_q == C_DAT_LST) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = w_rx_next[DATA_W-1:0];
            cnt_d     = '0;
            if (BURST) begin
              addr_d = addr_q + C_ADR_ONE;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        RD_WAIT: begin
          // rd_valid is only meaningful from the cycle after rd_req.
          if (rd_valid_i && !rd_req_q) begin
            w_tx_load = 1'b1;
            miso_d    = 1'b1;
            state_d   = RSTART;
          end
        end
        RSTART: begin
          miso_d     = w_tx_sout;
          w_tx_shift = 1'b1;
          cnt_d      = '0;
          state_d    = RDATA;
        end
        RDATA: begin
          // The MSB already left in RSTART, so DATA_W-1 more shifts here.
          if (cnt_q == C_DAT_LST) begin
            cnt_d = '0;
            if (BURST) begin
              addr_d    = addr_q + C_ADR_ONE;
              rd_addr_d = addr_q + C_ADR_ONE;
              rd_req_d  = 1'b1;
              state_d   = RD_WAIT;
            end else begin
              state_d = IGNORE;
            end
          end else begin
            miso_d     = w_tx_sout;
            w_tx_shift = 1'b1;
            cnt_d      = cnt_q + C_CNT_ONE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      opc_q     <= '0;
      miso_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      opc_q     <= opc_d;
      miso_q    <= miso_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign miso_o    = miso_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign rd_req_o  = rd_req_q;
  assign rd_addr_o = rd_addr_q;
  assign busy_o    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_slave_burst.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_ram_slave_burst
//  Purpose  : Self-checking bench for spi_ram_slave_burst (ADDR_W=DATA_W=8).
//             Frames are built as bit streams; expected outputs per cycle are
//             derived from the frame rules (offsets relative to the cycle
//             ss_n is first sampled low) and compared against what was seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_ram_slave_burst;

  localparam int A    = 8;
  localparam int D    = 8;
  localparam int MAXL = 128;

`ifdef SPI_SLV_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       rd_valid = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       miso, wr_en, rd_req, busy;
  logic [7:0] wr_addr, wr_data, rd_addr;

  spi_ram_slave_burst #(.ADDR_W(A), .DATA_W(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .ss_n_i     (ss_n),
    .mosi_i     (mosi),
    .miso_o     (miso),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .rd_req_o   (rd_req),
    .rd_addr_o  (rd_addr),
    .rd_valid_i (rd_valid),
    .rd_data_i  (rd_data),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // RAM contents (read-only model) and frame stream
  logic [7:0] mem [256];
  bit         sb[$];

  // Per-frame observation log, indexed by offset from T
  int         T = 0;
  bit         rec = 1'b0;
  int         fixed_delay = 0;
  bit         o_busy[MAXL], o_wr[MAXL], o_rq[MAXL], o_miso[MAXL], rv_at[MAXL];
  logic [7:0] o_wa[MAXL], o_wd[MAXL], o_ra[MAXL];

  // Monitor + RAM responder; the upcoming posedge number is edge_n+1.
  int         pend_due = 0;
  bit         pend = 1'b0;
  logic [7:0] pend_addr = 8'h00;
  always @(negedge clk) begin : mon
    int cyc, off;
    cyc = edge_n + 1;
    off = cyc - T;
    if (rec && off >= 0 && off < MAXL) begin
      o_busy[off] = busy;   o_wr[off] = wr_en;  o_rq[off] = rd_req;
      o_miso[off] = miso;   o_wa[off] = wr_addr; o_wd[off] = wr_data;
      o_ra[off]   = rd_addr;
    end
    if (pend && cyc == pend_due) begin
      rd_valid = 1'b1;
      rd_data  = mem[pend_addr];
      pend     = 1'b0;
      if (rec && off >= 0 && off < MAXL) rv_at[off] = 1'b1;
    end else begin
      rd_valid = 1'b0;
      rd_data  = 8'($urandom);
    end
    if (rd_req === 1'b1) begin
      pend      = 1'b1;
      pend_addr = rd_addr;
      pend_due  = cyc + ((fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4)));
    end
  end

  task automatic push_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sb.push_back(v[i]);
  endtask

  function automatic logic [7:0] get_byte(input int p);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) v = {v[6:0], sb[p + i]};
    return v;
  endfunction

  // Expected behaviour derived from frame rules; L = cycles ss_n is low.
  task automatic check_frame(input int L);
    bit         e_busy[MAXL], e_wr[MAXL], e_rq[MAXL], e_miso[MAXL];
    logic [7:0] e_wa[MAXL], e_wd[MAXL], e_ra[MAXL];
    logic [1:0] opc;
    logic [7:0] a, dv;
    int         c, r, v, k;
    for (int i = 0; i < MAXL; i++) begin
      e_busy[i] = 0; e_wr[i] = 0; e_rq[i] = 0; e_miso[i] = 0;
      e_wa[i] = 0;   e_wd[i] = 0; e_ra[i] = 0;
    end
    for (int i = 1; i <= L; i++) e_busy[i] = 1'b1;
    opc = {sb[0], sb[1]};
    a   = get_byte(2);
    if (opc == 2'b00) begin
      k = 0;
      forever begin
        c = 3 + A + D * (k + 1);
        if (c > L) break;
        e_wr[c] = 1'b1;
        e_wa[c] = a + 8'(k);
        e_wd[c] = get_byte(2 + A + D * k);
        if (!BURST) break;
        k++;
      end
    end else if (opc == 2'b01) begin
      r = 3 + A;
      k = 0;
      while (r <= L) begin
        e_rq[r] = 1'b1;
        e_ra[r] = a + 8'(k);
        v = -1;
        for (int i = r + 1; i < L; i++) if (rv_at[i]) begin v = i; break; end
        if (v < 0) break;
        dv = mem[a + 8'(k)];
        if (v + 1 <= L) e_miso[v + 1] = 1'b1;
        for (int i = 0; i < D; i++) if (v + 2 + i <= L) e_miso[v + 2 + i] = dv[D - 1 - i];
        if (!BURST) break;
        r = v + D + 2;
        k++;
      end
    end
    for (int off = 1; off <= L + 6; off++) begin
      check($sformatf("busy@T+%0d", off),   o_busy[off], e_busy[off]);
      check($sformatf("wr_en@T+%0d", off),  o_wr[off],   e_wr[off]);
      check($sformatf("rd_req@T+%0d", off), o_rq[off],   e_rq[off]);
      check($sformatf("miso@T+%0d", off),   o_miso[off], e_miso[off]);
      if (e_wr[off]) begin
        check($sformatf("wr_addr@T+%0d", off), o_wa[off], e_wa[off]);
        check($sformatf("wr_data@T+%0d", off), o_wd[off], e_wd[off]);
      end
      if (e_rq[off]) check($sformatf("rd_addr@T+%0d", off), o_ra[off], e_ra[off]);
    end
  endtask

  task automatic run_frame(input int L);
    while (sb.size() < L + 16) sb.push_back(1'($urandom));
    for (int i = 0; i < MAXL; i++) begin
      o_busy[i] = 0; o_wr[i] = 0; o_rq[i] = 0; o_miso[i] = 0; rv_at[i] = 0;
      o_wa[i] = 0;   o_wd[i] = 0; o_ra[i] = 0;
    end
    @(negedge clk);
    T = edge_n + 1; ss_n = 1'b0; mosi = 1'b0; rec = 1'b1;
    for (int off = 1; off < L; off++) begin
      @(negedge clk);
      mosi = sb[off - 1];
    end
    @(negedge clk);
    ss_n = 1'b1; mosi = 1'b0;
    repeat (8) @(negedge clk);
    rec = 1'b0;
    check_frame(L);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, " busy"},    busy,    1'b0);
    check({pfx, " wr_en"},   wr_en,   1'b0);
    check({pfx, " rd_req"},  rd_req,  1'b0);
    check({pfx, " miso"},    miso,    1'b0);
    check({pfx, " wr_addr"}, wr_addr, 8'h00);
    check({pfx, " wr_data"}, wr_data, 8'h00);
    check({pfx, " rd_addr"}, rd_addr, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h5A;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single write
    sb.delete(); push_bits(8'h00, 2); push_bits(8'h3C, 8); push_bits(8'hA5, 8);
    run_frame(20);

    // Single read, response three cycles after rd_req
    fixed_delay = 3;
    sb.delete(); push_bits(8'h01, 2); push_bits(8'h10, 8);
    run_frame(26);
    fixed_delay = 0;

    // Reset asserted in the middle of a write frame
    sb.delete(); push_bits(8'h00, 2); push_bits(8'h77, 8); push_bits(8'h99, 8);
    @(negedge clk); ss_n = 1'b0;
    for (int j = 0; j < 10; j++) begin @(negedge clk); mosi = sb[j]; end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("midframe_rst");
    ss_n = 1'b1; rst = 1'b0; mosi = 1'b0;
    repeat (4) @(negedge clk);

    // Frame after reset completes normally
    sb.delete(); push_bits(8'h00, 2); push_bits(8'h3C, 8); push_bits(8'hA5, 8);
    run_frame(20);

    // Address wrap across two words (second only with burst)
    sb.delete(); push_bits(8'h00, 2); push_bits(8'hFF, 8); push_bits(8'h11, 8); push_bits(8'h22, 8);
    run_frame(28);

    // Abort after four data bits
    sb.delete(); push_bits(8'h00, 2); push_bits(8'h42, 8); push_bits(8'hC3, 8);
    run_frame(15);

    // Invalid opcode followed by 16 bits
    sb.delete(); push_bits(8'h02, 2); push_bits(8'h3C, 8); push_bits(8'hA5, 8);
    run_frame(20);

    // Randomised frames
    for (int n = 0; n < 40; n++) begin
      sb.delete();
      push_bits(8'($urandom_range(0, 3)), 2);
      for (int b = 0; b < 7; b++) push_bits(8'($urandom), 8);
      run_frame(int'($urandom_range(1, 60)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
